// File: rtl/mem_arb_pkg.sv
// Shared encodings for the single-port SRAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Sliced down to the instance's byte-lane count.
  localparam logic [63:0] WEB_IDLE = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response channels plus the SRAM macro pins, grouped as one bundle.
interface mem_port_arbiter_if #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32,
  parameter int BYTES     = 4
) ();
  logic                 if_req_valid;
  logic                 if_req_ready;
  logic [ADDR_SIZE-1:0] if_req_addr;
  logic                 if_rsp_valid;
  logic [WORD_SIZE-1:0] if_rsp_data;

  logic                 dm_req_valid;
  logic                 dm_req_ready;
  logic [ADDR_SIZE-1:0] dm_req_addr;
  logic                 dm_req_we;
  logic [BYTES-1:0]     dm_req_be;
  logic [WORD_SIZE-1:0] dm_req_wdata;
  logic                 dm_rsp_valid;
  logic [WORD_SIZE-1:0] dm_rsp_data;

  logic                 mem_oe;
  logic [BYTES-1:0]     mem_web;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_DI;
  logic [WORD_SIZE-1:0] mem_DO;

  // Arbiter view.
  modport slave (
    input  if_req_valid, if_req_addr,
    input  dm_req_valid, dm_req_addr, dm_req_we, dm_req_be, dm_req_wdata,
    input  mem_DI,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output dm_req_ready, dm_rsp_valid, dm_rsp_data,
    output mem_oe, mem_web, mem_addr, mem_DO
  );

  // Core + SRAM view.
  modport master (
    output if_req_valid, if_req_addr,
    output dm_req_valid, dm_req_addr, dm_req_we, dm_req_be, dm_req_wdata,
    output mem_DI,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_data,
    input  mem_oe, mem_web, mem_addr, mem_DO
  );
endinterface

// File: rtl/mem_arb_prio.sv
// Grant selection between IF and DM: DM wins ties unless IF has waited STARVE_MAX DM grants.
module mem_arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle_i,
  input  logic if_valid_i,
  input  logic dm_valid_i,
  output logic if_gnt_o,
  output logic dm_gnt_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          starved, can_gnt;

  assign starved  = (starve_q == SW'(STARVE_MAX));
  // Readies stay low while reset is held, even though the FSM already sits in IDLE.
  assign can_gnt  = idle_i & ~rst;
  assign dm_gnt_o = can_gnt & dm_valid_i & (~if_valid_i | ~starved);
  assign if_gnt_o = can_gnt & if_valid_i & (~dm_valid_i | starved);

  always_comb begin
    starve_d = starve_q;
    if (if_gnt_o)
      starve_d = '0;
    else if (dm_gnt_o && if_valid_i && !starved)
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port SRAM between instruction fetch (read-only) and data (read/write).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int WORD_SIZE  = 32,
  parameter int BYTES      = 4,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [BYTES-1:0] WEB_OFF = WEB_IDLE[BYTES-1:0];

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mem_oe_q, mem_oe_d;
  logic [BYTES-1:0]     mem_web_q, mem_web_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_do_q, mem_do_d;
  logic                 if_rsp_valid_q, if_rsp_valid_d;
  logic [WORD_SIZE-1:0] if_rsp_data_q, if_rsp_data_d;
  logic                 dm_rsp_valid_q, dm_rsp_valid_d;
  logic [WORD_SIZE-1:0] dm_rsp_data_q, dm_rsp_data_d;
  logic                 if_gnt, dm_gnt;

  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk        (clk),
    .rst        (rst),
    .idle_i     (state_q == IDLE),
    .if_valid_i (bus.if_req_valid),
    .dm_valid_i (bus.dm_req_valid),
    .if_gnt_o   (if_gnt),
    .dm_gnt_o   (dm_gnt)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    mem_oe_d       = mem_oe_q;
    mem_web_d      = mem_web_q;
    mem_addr_d     = mem_addr_q;
    mem_do_d       = mem_do_q;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    dm_rsp_valid_d = 1'b0;
    dm_rsp_data_d  = dm_rsp_data_q;
    case (state_q)
      IDLE: begin
        if (dm_gnt) begin
          owner_d    = OWN_DM;
          mem_addr_d = bus.dm_req_addr;
          if (bus.dm_req_we) begin
            state_d   = WRITE;
            mem_web_d = ~bus.dm_req_be;
            mem_do_d  = bus.dm_req_wdata;
          end else begin
            state_d  = READ;
            mem_oe_d = 1'b1;
            cnt_d    = CW'(RD_LAT);
          end
        end else if (if_gnt) begin
          owner_d    = OWN_IF;
          mem_addr_d = bus.if_req_addr;
          state_d    = READ;
          mem_oe_d   = 1'b1;
          cnt_d      = CW'(RD_LAT);
        end
      end
      READ: begin
        // oe covers the RD_LAT wait plus the capture cycle.
        if (cnt_q == '0) begin
          state_d  = IDLE;
          mem_oe_d = 1'b0;
          if (owner_q == OWN_DM) begin
            dm_rsp_valid_d = 1'b1;
            dm_rsp_data_d  = bus.mem_DI;
          end else begin
            if_rsp_valid_d = 1'b1;
            if_rsp_data_d  = bus.mem_DI;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WRITE: begin
        state_d        = IDLE;
        mem_web_d      = WEB_OFF;
        dm_rsp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_IF;
      cnt_q          <= '0;
      mem_oe_q       <= 1'b0;
      mem_web_q      <= WEB_OFF;
      mem_addr_q     <= '0;
      mem_do_q       <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      dm_rsp_valid_q <= 1'b0;
      dm_rsp_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      cnt_q          <= cnt_d;
      mem_oe_q       <= mem_oe_d;
      mem_web_q      <= mem_web_d;
      mem_addr_q     <= mem_addr_d;
      mem_do_q       <= mem_do_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      dm_rsp_valid_q <= dm_rsp_valid_d;
      dm_rsp_data_q  <= dm_rsp_data_d;
    end
  end

  assign bus.if_req_ready = if_gnt;
  assign bus.dm_req_ready = dm_gnt;
  assign bus.if_rsp_valid = if_rsp_valid_q;
  assign bus.if_rsp_data  = if_rsp_data_q;
  assign bus.dm_rsp_valid = dm_rsp_valid_q;
  assign bus.dm_rsp_data  = dm_rsp_data_q;
  assign bus.mem_oe       = mem_oe_q;
  assign bus.mem_web      = mem_web_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_DO       = mem_do_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench: RD_LAT=1 instance with a byte-write SRAM model, RD_LAT=3 instance with a pattern ROM.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_SIZE(32), .WORD_SIZE(32), .BYTES(4)) b1 ();
  mem_port_arbiter_if #(.ADDR_SIZE(32), .WORD_SIZE(32), .BYTES(4)) b3 ();

  mem_port_arbiter #(.ADDR_SIZE(32), .WORD_SIZE(32), .BYTES(4), .RD_LAT(1), .STARVE_MAX(4))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  mem_port_arbiter #(.ADDR_SIZE(32), .WORD_SIZE(32), .BYTES(4), .RD_LAT(3), .STARVE_MAX(4))
    dut3 (.clk(clk), .rst(rst), .bus(b3));

  int n_chk = 0;
  int n_fail = 0;

  // SRAM for dut1 and an independent reference image updated from request semantics.
  logic [31:0] sram    [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] dm_last = 32'h0;
  logic [31:0] if_q[$], dm_q[$], if3_q[$], dm3_q[$];
  int          grants[$];

  assign b1.mem_DI = b1.mem_oe ? sram[b1.mem_addr[9:2]] : 32'h0;
  assign b3.mem_DI = b3.mem_oe ? (b3.mem_addr ^ 32'hA5A5_0000) : 32'h0;

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (!b1.mem_web[i]) sram[b1.mem_addr[9:2]][i*8 +: 8] <= b1.mem_DO[i*8 +: 8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // dut1 monitor: responses popped before this cycle's accept is pushed.
  always @(negedge clk) begin
    if (rst) begin
      if_q.delete();
      dm_q.delete();
      dm_last = 32'h0;
    end else begin
      if (b1.if_rsp_valid) begin
        if (if_q.size() == 0) chk("if_rsp_unexpected", 32'd1, 32'd0);
        else                  chk("if_rsp_data", b1.if_rsp_data, if_q.pop_front());
      end
      if (b1.dm_rsp_valid) begin
        if (dm_q.size() == 0) chk("dm_rsp_unexpected", 32'd1, 32'd0);
        else                  chk("dm_rsp_data", b1.dm_rsp_data, dm_q.pop_front());
      end
      if (b1.if_req_valid && b1.if_req_ready) begin
        grants.push_back(0);
        if_q.push_back(ref_mem[b1.if_req_addr[9:2]]);
      end
      if (b1.dm_req_valid && b1.dm_req_ready) begin
        grants.push_back(1);
        if (b1.dm_req_we) begin
          dm_q.push_back(dm_last);
          for (int i = 0; i < 4; i++)
            if (b1.dm_req_be[i]) ref_mem[b1.dm_req_addr[9:2]][i*8 +: 8] = b1.dm_req_wdata[i*8 +: 8];
        end else begin
          dm_last = ref_mem[b1.dm_req_addr[9:2]];
          dm_q.push_back(dm_last);
        end
      end
    end
  end

  // dut3 monitor: pattern ROM returns addr ^ A5A50000.
  always @(negedge clk) begin
    if (rst) begin
      if3_q.delete();
      dm3_q.delete();
    end else begin
      if (b3.if_rsp_valid) begin
        if (if3_q.size() == 0) chk("if3_rsp_unexpected", 32'd1, 32'd0);
        else                   chk("if3_rsp_data", b3.if_rsp_data, if3_q.pop_front());
      end
      if (b3.dm_rsp_valid) begin
        if (dm3_q.size() == 0) chk("dm3_rsp_unexpected", 32'd1, 32'd0);
        else                   chk("dm3_rsp_data", b3.dm_rsp_data, dm3_q.pop_front());
      end
      if (b3.if_req_valid && b3.if_req_ready) if3_q.push_back(b3.if_req_addr ^ 32'hA5A5_0000);
      if (b3.dm_req_valid && b3.dm_req_ready) dm3_q.push_back(b3.dm_req_addr ^ 32'hA5A5_0000);
    end
  end

  // Returns at the falling edge of the accept cycle T.
  task automatic wait_acc(input bit d3, input bit dm, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (d3) ok = dm ? (b3.dm_req_valid && b3.dm_req_ready) : (b3.if_req_valid && b3.if_req_ready);
      else    ok = dm ? (b1.dm_req_valid && b1.dm_req_ready) : (b1.if_req_valid && b1.if_req_ready);
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no accept within 20 cycles", nm);
    end
  endtask

  task automatic wait_rsp1(input bit dm, input logic [31:0] exp, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = dm ? b1.dm_rsp_valid : b1.if_rsp_valid;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no response within 20 cycles", nm);
    end else begin
      chk(nm, dm ? b1.dm_rsp_data : b1.if_rsp_data, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dm_drive(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
    b1.dm_req_valid = 1'b1;
    b1.dm_req_addr  = a;
    b1.dm_req_we    = we;
    b1.dm_req_be    = be;
    b1.dm_req_wdata = wd;
  endtask

  int exp_gnt [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
    sram[64]    = 32'hDEAD_BEEF;
    ref_mem[64] = 32'hDEAD_BEEF;
    b1.if_req_valid = 1'b1; b1.if_req_addr = 32'h0;
    dm_drive(32'h0, 1'b0, 4'h0, 32'h0);
    b3.if_req_valid = 1'b0; b3.if_req_addr = 32'h0;
    b3.dm_req_valid = 1'b0; b3.dm_req_addr = 32'h0; b3.dm_req_we = 1'b0;
    b3.dm_req_be = 4'h0; b3.dm_req_wdata = 32'h0;

    // Reset held with both requests pending.
    repeat (2) @(negedge clk);
    chk("rst_if_ready", {31'd0, b1.if_req_ready}, 32'd0);
    chk("rst_dm_ready", {31'd0, b1.dm_req_ready}, 32'd0);
    chk("rst_mem_oe", {31'd0, b1.mem_oe}, 32'd0);
    chk("rst_mem_web", {28'd0, b1.mem_web}, 32'hF);
    chk("rst_mem_addr", b1.mem_addr, 32'h0);
    chk("rst_rsp", {30'd0, b1.if_rsp_valid, b1.dm_rsp_valid}, 32'd0);
    step();
    b1.if_req_valid = 1'b0;
    b1.dm_req_valid = 1'b0;
    rst = 1'b0;
    step();

    // IF read, RD_LAT=1.
    b1.if_req_valid = 1'b1; b1.if_req_addr = 32'h100;
    wait_acc(1'b0, 1'b0, "if_rd_acc");
    step(); b1.if_req_valid = 1'b0;
    @(negedge clk);
    chk("if_rd_oe_t1", {31'd0, b1.mem_oe}, 32'd1);
    chk("if_rd_addr_t1", b1.mem_addr, 32'h100);
    chk("if_rd_web_t1", {28'd0, b1.mem_web}, 32'hF);
    @(negedge clk);
    chk("if_rd_oe_t2", {31'd0, b1.mem_oe}, 32'd1);
    chk("if_rd_rspv_t2", {31'd0, b1.if_rsp_valid}, 32'd0);
    @(negedge clk);
    chk("if_rd_oe_t3", {31'd0, b1.mem_oe}, 32'd0);
    chk("if_rd_rspv_t3", {31'd0, b1.if_rsp_valid}, 32'd1);
    chk("if_rd_data_t3", b1.if_rsp_data, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("if_rd_rspv_t4", {31'd0, b1.if_rsp_valid}, 32'd0);
    step();

    // DM partial write, then read back.
    dm_drive(32'h200, 1'b1, 4'b0011, 32'h1234_5678);
    wait_acc(1'b0, 1'b1, "dm_wr_acc");
    step(); b1.dm_req_valid = 1'b0;
    @(negedge clk);
    chk("dm_wr_web_t1", {28'd0, b1.mem_web}, 32'hC);
    chk("dm_wr_do_t1", b1.mem_DO, 32'h1234_5678);
    chk("dm_wr_oe_t1", {31'd0, b1.mem_oe}, 32'd0);
    chk("dm_wr_addr_t1", b1.mem_addr, 32'h200);
    @(negedge clk);
    chk("dm_wr_web_t2", {28'd0, b1.mem_web}, 32'hF);
    chk("dm_wr_ack_t2", {31'd0, b1.dm_rsp_valid}, 32'd1);
    step();
    dm_drive(32'h200, 1'b0, 4'h0, 32'h0);
    wait_acc(1'b0, 1'b1, "dm_rd_acc");
    step(); b1.dm_req_valid = 1'b0;
    wait_rsp1(1'b1, 32'h0000_5678, "dm_rd_merge");
    step();

    // Zero byte-enable write still acks, never strobes web.
    dm_drive(32'h100, 1'b1, 4'b0000, 32'hFFFF_FFFF);
    wait_acc(1'b0, 1'b1, "dm_be0_acc");
    step(); b1.dm_req_valid = 1'b0;
    @(negedge clk);
    chk("dm_be0_web_t1", {28'd0, b1.mem_web}, 32'hF);
    @(negedge clk);
    chk("dm_be0_ack", {31'd0, b1.dm_rsp_valid}, 32'd1);
    chk("dm_be0_data_hold", b1.dm_rsp_data, 32'h0000_5678);
    step();
    b1.if_req_valid = 1'b1; b1.if_req_addr = 32'h100;
    wait_acc(1'b0, 1'b0, "if_after_be0_acc");
    step(); b1.if_req_valid = 1'b0;
    wait_rsp1(1'b0, 32'hDEAD_BEEF, "if_after_be0_data");
    step();

    // Starvation: both held, DM writes only.
    grants.delete();
    b1.if_req_valid = 1'b1; b1.if_req_addr = 32'h104;
    dm_drive(32'h300, 1'b1, 4'hF, 32'hCAFE_0000);
    for (int i = 0; i < 200 && grants.size() < 10; i++) begin
      @(negedge clk);
      #1;
    end
    step();
    b1.if_req_valid = 1'b0;
    b1.dm_req_valid = 1'b0;
    chk("starve_grant_count", grants.size(), 32'd10);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      chk($sformatf("starve_grant_%0d", i), grants[i], exp_gnt[i]);
    repeat (6) step();

    // Reset mid-read drops the access.
    b1.if_req_valid = 1'b1; b1.if_req_addr = 32'h100;
    wait_acc(1'b0, 1'b0, "if_rst_acc");
    step(); b1.if_req_valid = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rstmid_oe", {31'd0, b1.mem_oe}, 32'd0);
    chk("rstmid_web", {28'd0, b1.mem_web}, 32'hF);
    for (int i = 0; i < 5; i++) begin
      chk("rstmid_no_rsp", {31'd0, b1.if_rsp_valid}, 32'd0);
      @(negedge clk);
    end
    step();

    // RD_LAT=3 DM read with IF queued behind it.
    b3.dm_req_valid = 1'b1; b3.dm_req_addr = 32'h40; b3.dm_req_we = 1'b0;
    wait_acc(1'b1, 1'b1, "lat3_dm_acc");
    step();
    b3.dm_req_valid = 1'b0;
    b3.if_req_valid = 1'b1; b3.if_req_addr = 32'h80;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("lat3_oe_t%0d", i), {31'd0, b3.mem_oe}, 32'd1);
      chk($sformatf("lat3_ifrdy_t%0d", i), {31'd0, b3.if_req_ready}, 32'd0);
    end
    @(negedge clk);
    chk("lat3_oe_t5", {31'd0, b3.mem_oe}, 32'd0);
    chk("lat3_dmrsp_t5", {31'd0, b3.dm_rsp_valid}, 32'd1);
    chk("lat3_dmdata_t5", b3.dm_rsp_data, 32'hA5A5_0040);
    chk("lat3_ifrdy_t5", {31'd0, b3.if_req_ready}, 32'd1);
    step();
    b3.if_req_valid = 1'b0;
    repeat (8) @(negedge clk);

    chk("if_q_empty", if_q.size(), 32'd0);
    chk("dm_q_empty", dm_q.size(), 32'd0);
    chk("if3_q_empty", if3_q.size(), 32'd0);
    chk("dm3_q_empty", dm3_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
